// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the IF/MEM byte-port arbiter: reset level, width codes, owner tags, IO base, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_ctrl_pkg;

   localparam logic RstEnable = 1'b1;

   // MEM access width codes as presented on mem_width
   localparam logic [1:0] WIDTH_BYTE = 2'd0;
   localparam logic [1:0] WIDTH_HALF = 2'd1;
   localparam logic [1:0] WIDTH_WORD = 2'd2;

   // Owner tag of the byte on mem_ctrl_data
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IF   = 2'b01;
   localparam logic [1:0] OWN_MEM  = 2'b10;

   // Stores into the 64 KiB page starting here wait on io_buffer_full
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MEM  = 1'b1
   } state_t;

   // Byte count of a MEM access; code 3 is treated as a word
   function automatic logic [2:0] width_to_n(input logic [1:0] w);
      logic [2:0] n;
      case (w)
         WIDTH_BYTE: n = 3'd1;
         WIDTH_HALF: n = 3'd2;
         WIDTH_WORD: n = 3'd4;
         default:    n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between IF (passthrough) and MEM (1/2/4-byte sequenced load/store), tagging returned bytes.
// Latency: IF byte 1 cycle after address; MEM store done at n+1, load done at n+2 cycles after request is sampled.
// Backpressure: rdy low freezes all state; IO stores hold while io_buffer_full; IF is stalled via stall_o while MEM owns the port.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_request,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [7:0]        mem_ctrl_data,
   output logic [1:0]        if_or_mem_o,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_width,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              stall_o,
   input  logic              io_buffer_full,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        n_q, n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              done_q, done_d;
   logic [1:0]        tag_q, tag_d;
   logic              stall_hold_q, stall_hold_d;

   logic              stall_c;
   logic              ram_wr_c;
   logic [ADDR_W-1:0] ram_a_c;
   logic [ADDR_W-1:0] reissue_a;
   logic [7:0]        ram_dout_c;
   logic              io_hold;
   logic [1:0]        issue_idx;
   logic [1:0]        cap_idx;

   assign issue_idx = cnt_q[1:0];
   assign cap_idx   = cnt_q[1:0] - 2'd1;
   assign io_hold   = we_q & io_buffer_full &
                      (addr_q[ADDR_W-1 -: 16] == IO_BASE[ADDR_W-1 -: 16]);
   assign stall_c   = (state_q != S_IDLE) | (mem_req & ~done_q);
   // Address of the load byte whose capture is still pending
   assign reissue_a = addr_q + ADDR_W'(cnt_q) - ADDR_W'(1);

   assign mem_ctrl_data = ram_din;
   assign if_or_mem_o   = tag_q;
   assign mem_rdata     = rdata_q;
   assign mem_done      = done_q;

   // Next-state: IF passthrough or MEM latch in IDLE, byte issue/capture sequencing in MEM
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      n_d          = n_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      done_d       = 1'b0;
      tag_d        = OWN_NONE;
      stall_hold_d = stall_c;
      ram_a_c      = '0;
      ram_wr_c     = 1'b0;
      ram_dout_c   = 8'h00;
      case (state_q)
         S_IDLE: begin
            // A request still high in the done cycle is the old one and is ignored
            if (mem_req && !done_q) begin
               state_d = S_MEM;
               cnt_d   = 3'd0;
               n_d     = width_to_n(mem_width);
               addr_d  = mem_addr;
               we_d    = mem_we;
               wdata_d = mem_wdata;
               if (!mem_we) begin
                  rdata_d = 32'h0;
               end
            end else if (if_request) begin
               ram_a_c = if_addr;
               tag_d   = OWN_IF;
            end
         end
         S_MEM: begin
            // Byte issued last cycle is on ram_din now
            if (!we_q && cnt_q != 3'd0) begin
               rdata_d[{cap_idx, 3'b000} +: 8] = ram_din;
            end
            if (cnt_q < n_q) begin
               if (!io_hold) begin
                  ram_a_c    = addr_q + ADDR_W'(cnt_q);
                  ram_wr_c   = we_q;
                  ram_dout_c = we_q ? wdata_q[{issue_idx, 3'b000} +: 8] : 8'h00;
                  cnt_d      = cnt_q + 3'd1;
                  if (!we_q) begin
                     tag_d = OWN_MEM;
                  end else if ((cnt_q + 3'd1) == n_q) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end else begin
               // Final load capture cycle
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // RAM-side outputs: quiet during reset, no writes and held stall while frozen.
   // While frozen with a load capture pending, the pending byte's address is
   // re-presented so ram_din still carries it when rdy returns.
   always_comb begin
      ram_a    = ram_a_c;
      ram_wr   = ram_wr_c;
      ram_dout = ram_dout_c;
      stall_o  = stall_c;
      if (rst == RstEnable) begin
         ram_a    = '0;
         ram_wr   = 1'b0;
         ram_dout = 8'h00;
         stall_o  = 1'b0;
      end else if (!rdy) begin
         ram_wr  = 1'b0;
         stall_o = stall_hold_q;
         if (state_q == S_MEM && !we_q && cnt_q != 3'd0) begin
            ram_a = reissue_a;
         end
      end
   end

   // State registers: synchronous reset, frozen while rdy is low
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         n_q          <= 3'd0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= 32'h0;
         rdata_q      <= 32'h0;
         done_q       <= 1'b0;
         tag_q        <= OWN_NONE;
         stall_hold_q <= 1'b0;
      end else if (rdy) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         n_q          <= n_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         tag_q        <= tag_d;
         stall_hold_q <= stall_hold_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a cycle-budget and byte-memory model.
// Latency: n/a.
// Backpressure: drives rdy and io_buffer_full patterns, directed and random.
module tb_mem_ctrl;

   localparam int RAM_SZ = 262144;

   logic        clk = 1'b0;
   logic        rst, rdy, if_request, mem_req, mem_we, io_buffer_full;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_width;
   logic [7:0]  mem_ctrl_data, ram_dout, ram_din;
   logic [1:0]  if_or_mem_o;
   logic [31:0] mem_rdata, ram_a;
   logic        mem_done, stall_o, ram_wr;

   logic [7:0]  ram     [RAM_SZ];
   logic [7:0]  ref_mem [RAM_SZ];
   bit          ram_ready = 1'b0;

   int          n_cmp, n_mis;
   logic [31:0] exp_rdata;
   int          dc;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_request(if_request), .if_addr(if_addr),
      .mem_ctrl_data(mem_ctrl_data), .if_or_mem_o(if_or_mem_o),
      .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_done(mem_done), .stall_o(stall_o), .io_buffer_full(io_buffer_full),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   function automatic logic [7:0] init_byte(input int unsigned i);
      logic [31:0] v;
      v = i;
      if (i < 16) return 8'hA0 + v[7:0];
      return v[7:0] ^ v[15:8] ^ 8'h3C;
   endfunction

   function automatic int unsigned ridx(input logic [31:0] a);
      return a & 32'h0003_FFFF;
   endfunction

   // Synchronous-read RAM, one cycle read latency
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < RAM_SZ; i++) ram[i] <= init_byte(i);
         ram_ready <= 1'b1;
      end else begin
         ram_din <= ram[ridx(ram_a)];
         if (ram_wr) ram[ridx(ram_a)] <= ram_dout;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // One MEM access. Caller is 1 time unit past a rising edge; returns the same way.
   // Expected timing: progress counter p advances on every cycle that is not lost
   // (rdy low, or an IO store byte blocked by io_buffer_full); done when p reaches
   // n+1 (store) or n+2 (load).
   task automatic do_mem(input string tag, input bit we, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit ifreq, input logic [31:0] ifa,
                         input logic [31:0] rdy_low_mask, input logic [31:0] io_mask,
                         input bit rnd, output int done_cyc);
      int n, target, p, obs_wr, tcnt;
      bit is_io, got, lost;
      n      = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      target = we ? n + 1 : n + 2;
      is_io  = (a[31:16] == 16'h0003);
      p = 0; obs_wr = 0; tcnt = 0; got = 1'b0; done_cyc = -1;
      mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wdata = wd;
      if_request = ifreq; if_addr = ifa; rdy = 1'b1; io_buffer_full = rnd ? 1'b0 : io_mask[0];
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         if (ram_wr) obs_wr++;
         if (p == target) begin
            check_val({tag, "_done"}, 32'(mem_done), 32'd1);
            check_val({tag, "_stall_done"}, 32'(stall_o), 32'd0);
            check_val({tag, "_if_a_done"}, ram_a, ifreq ? ifa : 32'h0);
            done_cyc = c;
            got = 1'b1;
         end else begin
            lost = !rdy || (we && is_io && io_buffer_full && p >= 1 && p <= n);
            check_val({tag, "_nodone"}, 32'(mem_done), 32'd0);
            check_val({tag, "_stall"}, 32'(stall_o), 32'd1);
            if (!rdy) begin
               check_val({tag, "_frozen_wr"}, 32'(ram_wr), 32'd0);
            end else if (p == 0) begin
               check_val({tag, "_acc_a"}, ram_a, 32'h0);
               check_val({tag, "_acc_wr"}, 32'(ram_wr), 32'd0);
            end else if (p <= n) begin
               if (lost) begin
                  check_val({tag, "_hold_wr"}, 32'(ram_wr), 32'd0);
               end else begin
                  check_val({tag, "_iss_a"}, ram_a, a + 32'(p - 1));
                  check_val({tag, "_iss_wr"}, 32'(ram_wr), 32'(we));
                  if (we) check_val({tag, "_iss_d"}, 32'(ram_dout), 32'(wd[8*(p-1) +: 8]));
               end
            end
            if (rdy && if_or_mem_o == 2'b10) begin
               check_val({tag, "_ld_byte"}, 32'(mem_ctrl_data), 32'(ref_mem[ridx(a + 32'(tcnt))]));
               tcnt++;
            end
            if (!lost) p++;
         end
         next_cyc();
         if (!got) begin
            if (rnd) begin
               rdy = (p == target) ? 1'b1 : ($urandom_range(0, 4) != 0);
               io_buffer_full = ($urandom_range(0, 2) == 0);
            end else begin
               rdy = (p == target) ? 1'b1 : !((c + 1 < 32) && rdy_low_mask[c + 1]);
               io_buffer_full = (c + 1 < 32) && io_mask[c + 1];
            end
         end
      end
      if (!got) check_val({tag, "_timeout"}, 32'd0, 32'd1);
      mem_req = 1'b0; if_request = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
      // Reference memory / load data update
      if (we) begin
         for (int k = 0; k < n; k++) ref_mem[ridx(a + 32'(k))] = wd[8*k +: 8];
      end else begin
         exp_rdata = 32'h0;
         for (int k = 0; k < n; k++) exp_rdata[8*k +: 8] = ref_mem[ridx(a + 32'(k))];
      end
      @(negedge clk);
      check_val({tag, "_pulse1"}, 32'(mem_done), 32'd0);
      if (ifreq) check_val({tag, "_if_tag"}, 32'(if_or_mem_o), 32'h1);
      check_val({tag, "_rdata"}, mem_rdata, exp_rdata);
      check_val({tag, "_nwr"}, 32'(obs_wr), we ? 32'(n) : 32'd0);
      check_val({tag, "_ntag"}, 32'(tcnt), we ? 32'd0 : 32'(n));
      next_cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_mis = 0; exp_rdata = 32'h0;
      for (int i = 0; i < RAM_SZ; i++) ref_mem[i] = init_byte(i);
      rst = 1'b1; rdy = 1'b1; if_request = 1'b0; if_addr = 32'h0; mem_req = 1'b0;
      mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0; io_buffer_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Outputs quiet while reset is held even with requests present
      if_request = 1'b1; if_addr = 32'h55; mem_req = 1'b1;
      @(negedge clk);
      check_val("rst_ram_a", ram_a, 32'h0);
      check_val("rst_ram_wr", 32'(ram_wr), 32'd0);
      check_val("rst_stall", 32'(stall_o), 32'd0);
      check_val("rst_dout", 32'(ram_dout), 32'd0);
      next_cyc();
      rst = 1'b0; if_request = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      check_val("rst_tag", 32'(if_or_mem_o), 32'd0);
      check_val("rst_done", 32'(mem_done), 32'd0);
      check_val("rst_rdata", mem_rdata, 32'h0);
      check_val("rst_stall2", 32'(stall_o), 32'd0);
      next_cyc();

      // IF byte stream
      for (int k = 0; k < 4; k++) begin
         if_request = 1'b1; if_addr = 32'(k);
         @(negedge clk);
         check_val("if_a", ram_a, 32'(k));
         check_val("if_stall", 32'(stall_o), 32'd0);
         if (k > 0) begin
            check_val("if_data", 32'(mem_ctrl_data), 32'(8'hA0 + 8'(k - 1)));
            check_val("if_tag", 32'(if_or_mem_o), 32'h1);
         end
         next_cyc();
      end
      if_request = 1'b0;
      @(negedge clk);
      check_val("if_data_last", 32'(mem_ctrl_data), 32'hA3);
      check_val("if_tag_last", 32'(if_or_mem_o), 32'h1);
      next_cyc();
      @(negedge clk);
      check_val("if_tag_idle", 32'(if_or_mem_o), 32'h0);
      next_cyc();

      // Directed MEM accesses
      do_mem("sw100", 1'b1, 2'd2, 32'h100, 32'h4433_2211, 1'b0, 0, 0, 0, 1'b0, dc);
      check_val("sw100_cyc", 32'(dc), 32'd5);
      do_mem("lw100", 1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 0, 0, 0, 1'b0, dc);
      check_val("lw100_cyc", 32'(dc), 32'd6);
      check_val("lw100_val", mem_rdata, 32'h4433_2211);
      do_mem("sh200", 1'b1, 2'd1, 32'h200, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 1'b0, dc);
      check_val("sh200_cyc", 32'(dc), 32'd3);
      check_val("sh200_keep", mem_rdata, 32'h4433_2211);
      do_mem("lb201", 1'b0, 2'd0, 32'h201, 32'h0, 1'b0, 0, 0, 0, 1'b0, dc);
      check_val("lb201_cyc", 32'(dc), 32'd3);
      check_val("lb201_val", mem_rdata, 32'h0000_00BE);
      do_mem("sbio", 1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A, 1'b0, 0, 0, 32'h0000_000E, 1'b0, dc);
      check_val("sbio_cyc", 32'(dc), 32'd5);
      do_mem("lwrdy", 1'b0, 2'd2, 32'h100, 32'h0, 1'b1, 32'h7, 32'h0000_0018, 0, 1'b0, dc);
      check_val("lwrdy_cyc", 32'(dc), 32'd8);
      check_val("lwrdy_val", mem_rdata, 32'h4433_2211);
      do_mem("wd3", 1'b1, 2'd3, 32'h300, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 1'b0, dc);
      check_val("wd3_cyc", 32'(dc), 32'd5);

      // Reset in the middle of a word load
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd2; mem_addr = 32'h100;
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      check_val("rstmid_a1", ram_a, 32'h100);
      next_cyc();
      rst = 1'b1; mem_req = 1'b0;
      @(negedge clk);
      check_val("rstmid_wr", 32'(ram_wr), 32'd0);
      check_val("rstmid_a", ram_a, 32'h0);
      check_val("rstmid_stall", 32'(stall_o), 32'd0);
      next_cyc();
      rst = 1'b0; if_request = 1'b1; if_addr = 32'h5;
      exp_rdata = 32'h0;
      @(negedge clk);
      check_val("rstmid_stall2", 32'(stall_o), 32'd0);
      check_val("rstmid_tag", 32'(if_or_mem_o), 32'd0);
      check_val("rstmid_done", 32'(mem_done), 32'd0);
      check_val("rstmid_if_a", ram_a, 32'h5);
      next_cyc();
      if_request = 1'b0;
      @(negedge clk);
      check_val("rstmid_if_data", 32'(mem_ctrl_data), 32'(ref_mem[5]));
      check_val("rstmid_if_tag", 32'(if_or_mem_o), 32'h1);
      check_val("rstmid_done2", 32'(mem_done), 32'd0);
      next_cyc();

      // Randomized accesses with random rdy drops and IO buffer pressure
      for (int t = 0; t < 30; t++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? (32'h0003_0000 + 32'($urandom_range(0, 32'h1F0)))
                                          : 32'($urandom_range(16, 32'h2FF0));
         do_mem("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)), 0, 0, 1'b1, dc);
         repeat ($urandom_range(0, 2)) next_cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the byte-serial fetch interface driven by the IF stage. It also serves the MEM stage.
- Arbitrates the single byte-wide RAM port between IF (one byte per cycle, address passthrough) and MEM (1/2/4-byte load/store sequenced internally).
- Tags returned bytes with their owner.
- Stalls IF via the ctrl stall bit while MEM owns the port.
- Sits between the IF/MEM stages and the external RAM/IO bus.

Parameters:
- IO_BASE, 32'h00030000, start of the IO region; writes there wait on io_buffer_full.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes the block
- if_request  in  1  IF wants a byte at if_addr this cycle
- if_addr  in  32  IF byte address
- mem_ctrl_data  out  8  byte returned to IF/MEM (ram_din passthrough)
- if_or_mem_o  out  2  owner of the byte on mem_ctrl_data: 01 IF, 10 MEM, 00 none
- mem_req  in  1  MEM access request (level, held until mem_done)
- mem_we  in  1  1 store, 0 load
- mem_width  in  2  0 byte, 1 half, 2 word (3 treated as word)
- mem_addr  in  32  MEM base byte address
- mem_wdata  in  32  store data, little-endian
- mem_rdata  out  32  load data, zero-extended raw bytes
- mem_done  out  1  one-cycle completion pulse
- stall_o  out  1  to ctrl; drives stall_sign[0]
- io_buffer_full  in  1  external IO write buffer full
- ram_din  in  8  RAM read data, valid one cycle after ram_a
- ram_dout  out  8  RAM write data
- ram_a  out  32  RAM address
- ram_wr  out  1  RAM write strobe

Behaviour:
- Reset (rst high at clk edge):
  - state=IDLE, cnt=0, if_or_mem_o=00, mem_rdata=0, mem_done=0, latched request cleared.
  - Comb outputs during reset: ram_wr=0, ram_a=0, ram_dout=0, stall_o=0.
  - Reset mid-operation aborts the access with no mem_done; partial stores are not rolled back.
- rdy low: no register updates; ram_wr forced 0; stall_o holds its current value.
- mem_ctrl_data = ram_din, combinational, always.
- IDLE with mem_req=0 or mem_done=1 (IF phase):
  - ram_a = if_addr when if_request, else 0; ram_wr=0.
  - Next cycle if_or_mem_o = 01 if if_request, else 00.
  - IF read latency: address in cycle t, byte valid on mem_ctrl_data in cycle t+1.
- mem_req in IDLE with mem_done=0: MEM priority.
  - stall_o=1 combinationally that cycle.
  - ram_a=0, ram_wr=0; next cycle if_or_mem_o=00.
  - Latch addr, we, n (1/2/4), wdata; cnt=0; next state MEM.
- stall_o = (state!=IDLE) | (state==IDLE & mem_req & !mem_done).
- MEM state, issue cycle for cnt<n:
  - ram_a = addr+cnt, 32-bit wrap.
  - Store: ram_wr=1, ram_dout = wdata[8cnt+7:8cnt].
  - Load: ram_wr=0, tag next cycle = 10.
  - cnt increments.
- IO hold: store with addr[31:16]==IO_BASE[31:16] and io_buffer_full=1:
  - ram_wr=0, ram_a=0; cnt holds.
  - Retry each cycle until io_buffer_full=0.
- Load capture: in the cycle after byte k is issued, mem_rdata[8k+7:8k] <= ram_din. Bytes above n stay 0; mem_rdata is cleared at latch time.
- Completion:
  - Store: after the last issue cycle, state returns to IDLE and mem_done=1 for exactly one cycle.
  - Load: one extra capture cycle, then the same.
- Timing, mem_req first sampled at edge of cycle 0:
  - Store n bytes: issue in cycles 1..n, mem_done high in cycle n+1.
  - Load: issue in cycles 1..n, capture through cycle n+1, mem_done high in cycle n+2.
- mem_rdata holds its value until the next MEM load latch.
- A held mem_req in the mem_done cycle is ignored; MEM must drop it. A new request is accepted no earlier than the cycle after mem_done.
- if_request is ignored while stall_o=1; IF re-issues its address after the stall.
- Simultaneous mem_req and if_request in IDLE: MEM wins; no IF byte is issued that cycle.

Decomposition:
- Shared defines header holds:
  - RstEnable
  - width codes (byte/half/word)
  - owner tags (01/10/00)
  - IO_BASE
  - FSM state encodings (IDLE, MEM)
- Single module; the byte sequencer is too small to split out.

Test Plan:
- IF stream: if_request=1, if_addr=0,1,2,3 on consecutive cycles, ram model returns 8'hAx for addr x → mem_ctrl_data=A0,A1,A2,A3 one cycle later each, if_or_mem_o=01, stall_o=0.
- LW at 0x100, ram 0x100..0x103 = 11,22,33,44 → stall_o high from cycle 0 to cycle 5; ram_a=0x100..0x103 in cycles 1-4; mem_rdata=32'h44332211 with mem_done in cycle 6; tags 10.
- SH at 0x200, wdata=32'hDEADBEEF → ram_wr with (0x200,EF) and (0x201,BE) in cycles 1-2; mem_done in cycle 3; no write to 0x202.
- SB at 0x30000 with io_buffer_full=1 for 3 cycles → ram_wr=0 during the hold; write of the byte occurs in the first cycle io_buffer_full=0; mem_done the next cycle.
- mem_req and if_request together, then rdy=0 for 2 cycles mid-load → MEM served first; no state change or ram_wr while rdy=0; load completes 2 cycles late with correct data.
- rst asserted in cycle 2 of an LW → mem_done never pulses; state IDLE, stall_o=0, if_or_mem_o=00 next cycle; IF fetch works immediately after.
